sorter_arbiter: RTL and testbench
=================================

Name: sorter_arbiter

Overview:
- Shares one `sorter` instance among NUM_REQ requesters using round-robin arbitration.
- Accepts a sort job (data vector, length, order) from the granted requester and registers it. Drives the sorter's launch handshake, waits for completion, and returns the sorted vector tagged with the requester ID on a valid/ready response channel.
- Sits between client blocks and the sorter, and holds the sorter's inputs stable for the whole sort.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, element width.
- LENGTH, 8, max elements per job; must match the sorter instance.
- TIMEOUT, 1024, watchdog limit in cycles per sort.
- Derived localparams: LW = $clog2(LENGTH+1); IW = $clog2(NUM_REQ); VW = LENGTH*DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester job valid
- req_ready  out  NUM_REQ  one-hot grant; a job transfers when valid&ready
- req_data  in  NUM_REQ*VW  requester k's vector at [k*VW +: VW]
- req_len  in  NUM_REQ*LW  requester k's length at [k*LW +: LW]
- req_order  in  NUM_REQ  0 = ascending, 1 = descending
- rsp_valid  out  1  sorted result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IW  requester that owns the result
- rsp_data  out  VW  sorted vector
- rsp_timeout  out  1  result aborted by watchdog; rsp_data holds the unsorted input
- srt_data_in  out  VW  to sorter data_in
- srt_len  out  LW  to sorter len
- srt_sort_en  out  1  to sorter sort_en
- srt_sort_order  out  1  to sorter sort_order
- srt_data_sorted  in  VW  from sorter
- srt_sort_done  in  1  from sorter; one-cycle pulse
- srt_sort_in_progress  in  1  from sorter

Behaviour:
Reset (asynchronous, immediate):
- State = IDLE; rr_ptr = 0.
- All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout, srt_sort_en, srt_data_in, srt_len, srt_sort_order.
- Reset mid-sort abandons the job with no response; the sorter is reset by the same rst.

FSM states: IDLE, LAUNCH, WAIT, SETTLE, RESP.

IDLE:
- Round-robin pick of the first requester with req_valid set, searching from rr_ptr upward with wrap.
- req_ready is combinational, one-hot, and asserted only in IDLE, so valid and ready overlap in the same cycle.
- On transfer, register data, order, id and clamped length: min(req_len, LENGTH). Set rr_ptr = id+1 mod NUM_REQ.
- If clamped len <= 1: go directly to RESP with rsp_data = input. The sorter is never launched, because len=0 is invalid for it.
- Else go to LAUNCH.

LAUNCH:
- srt_sort_en = 1 for exactly one cycle; clear the watchdog counter; go to WAIT.

WAIT:
- srt_data_in, srt_len and srt_sort_order stay held from the registered job until RESP exits. The sorter re-reads data_in throughout the sort, so these must not change.
- On srt_sort_done: capture srt_data_sorted into rsp_data, go to SETTLE.
- If the counter reaches TIMEOUT-1 first: rsp_data = registered input, rsp_timeout = 1, go to SETTLE.

SETTLE:
- One cycle, so the sorter returns to its idle state before any new launch; go to RESP.

RESP:
- rsp_valid = 1; rsp_id, rsp_data and rsp_timeout are stable while rsp_valid=1 && !rsp_ready.
- On rsp_ready: clear rsp_valid and rsp_timeout, go to IDLE.
- No new grant is issued in the RESP exit cycle, so the earliest next req_ready is the following cycle.

Latency and rules:
- Sorted job: 3 + sorter cycles, measured from transfer to rsp_valid.
- Bypass job (len <= 1): 1 cycle.
- srt_sort_done outside WAIT is ignored.
- req_valid may drop without a grant; a requester that is not granted is not recorded.
- At most one job is in flight; there is no queue.

Decomposition:
- Package sorter_pkg holds:
  - state enum arb_state_e {IDLE, LAUNCH, WAIT, SETTLE, RESP};
  - ORDER_ASC = 1'b0 and ORDER_DESC = 1'b1;
  - a function clamp_len().
- Sub-module rr_arbiter (NUM_REQ): inputs req and ptr; outputs one-hot gnt, gnt_id and any. It is combinational and reusable by other shared-resource controllers in the library.
- The top instantiates rr_arbiter. The sorter is instantiated by the parent, not inside this block.

Test Plan:
- Single job, requester 2: {5,3,8,1,9,2,7,4}, len=8, ascending -> rsp_id=2, rsp_data={1,2,3,4,5,7,8,9}, rsp_timeout=0.
- Requesters 0,1,3 valid simultaneously, rr_ptr=0, rsp_ready held high -> responses in order id 0, 1, 3. With all requesters re-asserted, the next grant is 0.
- Descending, len=5, data {4,9,1,9,6,x,x,x} -> rsp_data first five = {9,9,6,4,1}; upper three elements unchanged.
- Bypass: len=0 and len=1 -> rsp_valid one cycle after transfer, rsp_data = input, srt_sort_en never asserted. len=12 with LENGTH=8 -> srt_len=8.
- Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_data/rsp_id stable and req_ready=0 throughout; a pending requester is granted the cycle after the rsp_ready handshake. Separately, a stubbed sorter that never asserts done with TIMEOUT=16 -> rsp_timeout=1 after 16 WAIT cycles.
- Assert rst during WAIT -> all outputs 0 immediately; a new job after reset completes correctly.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the sorter arbitration wrapper.
package sorter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } arb_state_e;

    localparam logic ORDER_ASC  = 1'b0;
    localparam logic ORDER_DESC = 1'b1;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_id,
    output logic               any
);

    int idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                any         = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sorter_arbiter.sv
// Shares one external sorter among NUM_REQ requesters; one job in flight,
// sorter inputs held from the registered job until the response is taken.
module sorter_arbiter
    import sorter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int LENGTH     = 8,
    parameter  int TIMEOUT    = 1024,
    localparam int LW         = $clog2(LENGTH + 1),
    localparam int IW         = $clog2(NUM_REQ),
    localparam int VW         = LENGTH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*VW-1:0] req_data,
    input  logic [NUM_REQ*LW-1:0] req_len,
    input  logic [NUM_REQ-1:0]    req_order,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [VW-1:0]         rsp_data,
    output logic                  rsp_timeout,
    output logic [VW-1:0]         srt_data_in,
    output logic [LW-1:0]         srt_len,
    output logic                  srt_sort_en,
    output logic                  srt_sort_order,
    input  logic [VW-1:0]         srt_data_sorted,
    input  logic                  srt_sort_done,
    input  logic                  srt_sort_in_progress
);

    localparam int CW = $clog2(TIMEOUT);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       job_id_q, job_id_d;
    logic [VW-1:0]       job_data_q, job_data_d;
    logic [LW-1:0]       job_len_q, job_len_d;
    logic                job_order_q, job_order_d;
    logic [VW-1:0]       rsp_data_q, rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]       wd_cnt_q, wd_cnt_d;

    logic [VW-1:0]       req_data_arr [NUM_REQ];
    logic [LW-1:0]       req_len_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_id;
    logic                arb_any;
    logic [LW-1:0]       sel_len;
    logic                unused_in;

    // Completion is signalled by srt_sort_done alone; the busy flag is informational.
    assign unused_in = srt_sort_in_progress;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_data_arr[gi] = req_data[gi*VW +: VW];
        assign req_len_arr[gi]  = req_len[gi*LW +: LW];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign sel_len   = LW'(clamp_len(req_len_arr[arb_id], LENGTH));
    // Gated by rst so the grant is silent while reset is held.
    assign req_ready = (state_q == IDLE && !rst) ? arb_gnt : '0;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        job_id_d      = job_id_q;
        job_data_d    = job_data_q;
        job_len_d     = job_len_q;
        job_order_d   = job_order_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_cnt_d      = wd_cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    job_data_d    = req_data_arr[arb_id];
                    job_len_d     = sel_len;
                    job_order_d   = req_order[arb_id];
                    job_id_d      = arb_id;
                    rr_ptr_d      = (arb_id == IW'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
                    rsp_timeout_d = 1'b0;
                    // Length 0 is illegal for the sorter and length 1 is trivially sorted.
                    if (sel_len <= LW'(1)) begin
                        rsp_data_d = req_data_arr[arb_id];
                        state_d    = RESP;
                    end else begin
                        state_d    = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wd_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (srt_sort_done) begin
                    rsp_data_d = srt_data_sorted;
                    state_d    = SETTLE;
                end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d    = job_data_q;
                    rsp_timeout_d = 1'b1;
                    state_d       = SETTLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            SETTLE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            job_id_q      <= '0;
            job_data_q    <= '0;
            job_len_q     <= '0;
            job_order_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            job_id_q      <= job_id_d;
            job_data_q    <= job_data_d;
            job_len_q     <= job_len_d;
            job_order_q   <= job_order_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign srt_sort_en    = (state_q == LAUNCH);
    assign srt_data_in    = job_data_q;
    assign srt_len        = job_len_q;
    assign srt_sort_order = job_order_q;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_id         = job_id_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_timeout    = rsp_timeout_q;

endmodule

// File: tb/tb_sorter_arbiter.sv
// Bench for sorter_arbiter with a behavioural sorter stub and a queue-sort reference model.
module tb_sorter_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int LEN = 8;
    localparam int TO  = 16;
    localparam int LW  = $clog2(LEN + 1);
    localparam int IW  = $clog2(NR);
    localparam int VW  = LEN * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*VW-1:0]  req_data;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_order;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [VW-1:0]     rsp_data;
    logic              rsp_timeout;
    logic [VW-1:0]     srt_data_in;
    logic [LW-1:0]     srt_len;
    logic              srt_sort_en;
    logic              srt_sort_order;
    logic [VW-1:0]     srt_data_sorted;
    logic              srt_sort_done;
    logic              srt_sort_in_progress;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr = 0;
    int en_count = 0;
    bit stub_stall = 1'b0;
    bit hold_bad = 1'b0;
    logic extra_done = 1'b0;

    logic [VW-1:0] jd [NR];
    int            jl [NR];
    bit            jo [NR];

    always #5 clk = ~clk;

    sorter_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LENGTH(LEN), .TIMEOUT(TO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_data             (req_data),
        .req_len              (req_len),
        .req_order            (req_order),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_id               (rsp_id),
        .rsp_data             (rsp_data),
        .rsp_timeout          (rsp_timeout),
        .srt_data_in          (srt_data_in),
        .srt_len              (srt_len),
        .srt_sort_en          (srt_sort_en),
        .srt_sort_order       (srt_sort_order),
        .srt_data_sorted      (srt_data_sorted),
        .srt_sort_done        (srt_sort_done),
        .srt_sort_in_progress (srt_sort_in_progress)
    );

    // Reference: sort the first min(len,LEN) elements, leave the rest untouched.
    function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] d, input int len, input bit ord);
        int unsigned q[$];
        logic [VW-1:0] r;
        int l;
        r = d;
        l = (len > LEN) ? LEN : len;
        for (int i = 0; i < l; i++) q.push_back(d[i*DW +: DW]);
        if (ord) q.rsort();
        else q.sort();
        for (int i = 0; i < l; i++) r[i*DW +: DW] = q[i];
        return r;
    endfunction

    function automatic int next_grant(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < LEN; i++) r[i*DW +: DW] = $urandom_range(0, 20);
        return r;
    endfunction

    // Behavioural sorter: random latency, optional stall forever.
    logic          stub_busy;
    logic          stub_done;
    int            stub_cnt;
    logic [VW-1:0] stub_sorted;
    logic [VW-1:0] launch_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy   <= 1'b0;
            stub_done   <= 1'b0;
            stub_cnt    <= 0;
            stub_sorted <= '0;
            launch_data <= '0;
        end else begin
            stub_done <= 1'b0;
            if (srt_sort_en) begin
                stub_busy   <= 1'b1;
                stub_cnt    <= int'($urandom_range(2, 8));
                launch_data <= srt_data_in;
            end else if (stub_busy && !stub_stall) begin
                if (srt_data_in !== launch_data) hold_bad <= 1'b1;
                if (stub_cnt == 0) begin
                    stub_busy   <= 1'b0;
                    stub_done   <= 1'b1;
                    stub_sorted <= ref_sort(srt_data_in, int'(srt_len), srt_sort_order);
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    assign srt_data_sorted      = stub_sorted;
    assign srt_sort_done        = stub_done | extra_done;
    assign srt_sort_in_progress = stub_busy;

    always @(posedge clk) if (srt_sort_en) en_count <= en_count + 1;

    task automatic set_job(input int id, input logic [VW-1:0] d, input int len, input bit ord);
        jd[id] = d; jl[id] = len; jo[id] = ord;
        req_data[id*VW +: VW] = d;
        req_len[id*LW +: LW]  = LW'(len);
        req_order[id]         = ord;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_ptr = 0;
    endtask

    // Returns at the negedge after the transfer edge.
    task automatic send_job(input int id, input logic [VW-1:0] d, input int len, input bit ord,
                            output bit ok);
        @(negedge clk);
        set_job(id, d, len, ord);
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (req_ready[id]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output int cycles);
        ok = 1'b0; cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_timeout, srt_sort_en, srt_len, srt_sort_order} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b id=%0d to=%b en=%b len=%0d ord=%b want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_timeout, srt_sort_en, srt_len, srt_sort_order);
        end
        n_cmp++;
        if (rsp_data !== '0 || srt_data_in !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got rsp_data=%h srt_data_in=%h want 0", rsp_data, srt_data_in);
        end
        req_valid = '0;
        @(negedge clk); rst = 1'b0;
        model_ptr = 0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int unsigned vin [LEN] = '{5, 3, 8, 1, 9, 2, 7, 4};
        int unsigned vexp[LEN] = '{1, 2, 3, 4, 5, 7, 8, 9};
        logic [VW-1:0] d, e;
        bit ok; int cyc;
        for (int i = 0; i < LEN; i++) begin d[i*DW +: DW] = vin[i]; e[i*DW +: DW] = vexp[i]; end
        send_job(2, d, 8, 1'b0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_grant: no req_ready for requester 2"); end
        wait_rsp(ok, cyc);
        n_cmp++;
        if (!ok || rsp_id !== 2'd2) begin
            n_bad++; $display("FAIL single_id: got valid=%b id=%0d want 1/2", rsp_valid, rsp_id);
        end
        n_cmp++;
        if (rsp_data !== e || rsp_timeout !== 1'b0) begin
            n_bad++; $display("FAIL single_data: got %h to=%b want %h to=0", rsp_data, rsp_timeout, e);
        end
        accept_rsp();
        $display("test_single: id=%0d data=%h", rsp_id, rsp_data);
    endtask

    task automatic test_rr();
        bit ok; int cyc; int exp;
        logic [NR-1:0] mask;
        pulse_reset();
        for (int k = 0; k < NR; k++) set_job(k, rand_vec(), 8, 1'($urandom_range(0, 1)));
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            mask = (r < 3) ? 4'b1011 : 4'b1111;
            wait_rsp(ok, cyc);
            exp = next_grant(mask, model_ptr);
            model_ptr = (exp + 1) % NR;
            n_cmp++;
            if (!ok || int'(rsp_id) != exp || rsp_data !== ref_sort(jd[exp], jl[exp], jo[exp])) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got valid=%b id=%0d data=%h want id=%0d data=%h", r,
                         rsp_valid, rsp_id, rsp_data, exp, ref_sort(jd[exp], jl[exp], jo[exp]));
            end
            $display("test_rr: response %0d id=%0d", r, rsp_id);
            if (r == 2) req_valid = '1;
            if (r == 3) req_valid = '0;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_desc();
        int unsigned vin[5]  = '{4, 9, 1, 9, 6};
        int unsigned vexp[5] = '{9, 9, 6, 4, 1};
        logic [VW-1:0] d, e;
        bit ok; int cyc;
        d = rand_vec();
        for (int i = 0; i < 5; i++) d[i*DW +: DW] = vin[i];
        e = d;
        for (int i = 0; i < 5; i++) e[i*DW +: DW] = vexp[i];
        send_job(1, d, 5, 1'b1, ok);
        wait_rsp(ok, cyc);
        n_cmp++;
        if (!ok || rsp_data !== e || rsp_id !== 2'd1) begin
            n_bad++; $display("FAIL desc_data: got id=%0d %h want id=1 %h", rsp_id, rsp_data, e);
        end
        accept_rsp();
        $display("test_desc: data=%h", e);
    endtask

    task automatic test_bypass();
        logic [VW-1:0] d;
        bit ok; int cyc; int e0;
        for (int len = 0; len < 2; len++) begin
            d = rand_vec();
            e0 = en_count;
            send_job(0, d, len, 1'($urandom_range(0, 1)), ok);
            n_cmp++;
            if (!ok || rsp_valid !== 1'b1 || rsp_data !== d) begin
                n_bad++;
                $display("FAIL bypass_len%0d: got valid=%b data=%h want 1 %h", len, rsp_valid, rsp_data, d);
            end
            accept_rsp();
            n_cmp++;
            if (en_count != e0) begin
                n_bad++; $display("FAIL bypass_en%0d: got %0d launches want 0", len, en_count - e0);
            end
            $display("test_bypass: len=%0d data=%h", len, rsp_data);
        end
        d = rand_vec();
        send_job(3, d, 12, 1'b0, ok);
        n_cmp++;
        if (srt_len !== LW'(LEN)) begin
            n_bad++; $display("FAIL clamp_len: got srt_len=%0d want %0d", srt_len, LEN);
        end
        wait_rsp(ok, cyc);
        n_cmp++;
        if (!ok || rsp_data !== ref_sort(d, 12, 1'b0)) begin
            n_bad++; $display("FAIL clamp_data: got %h want %h", rsp_data, ref_sort(d, 12, 1'b0));
        end
        accept_rsp();
        $display("test_bypass: len=12 srt_len=8");
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] d, d3, snap;
        bit ok; bit bad; int cyc;
        d = rand_vec();
        d3 = rand_vec();
        send_job(1, d, 6, 1'b1, ok);
        wait_rsp(ok, cyc);
        n_cmp++;
        if (!ok || rsp_id !== 2'd1 || rsp_data !== ref_sort(d, 6, 1'b1)) begin
            n_bad++; $display("FAIL bp_first: got id=%0d %h want id=1 %h", rsp_id, rsp_data, ref_sort(d, 6, 1'b1));
        end
        snap = rsp_data;
        set_job(3, d3, 8, 1'b0);
        req_valid[3] = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== snap || rsp_id !== 2'd1 || req_ready !== '0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++; $display("FAIL bp_hold: got valid=%b id=%0d rdy=%b want stable 1/1/0000", rsp_valid, rsp_id, req_ready);
        end
        accept_rsp();
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_bad++; $display("FAIL bp_regrant: got req_ready=%b want 1000", req_ready);
        end
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_rsp(ok, cyc);
        n_cmp++;
        if (!ok || rsp_id !== 2'd3 || rsp_data !== ref_sort(d3, 8, 1'b0)) begin
            n_bad++; $display("FAIL bp_second: got id=%0d %h want id=3 %h", rsp_id, rsp_data, ref_sort(d3, 8, 1'b0));
        end
        accept_rsp();
        $display("test_backpressure: held 20 cycles, next id=3");
    endtask

    task automatic test_timeout();
        logic [VW-1:0] d;
        bit ok; int cyc;
        d = rand_vec();
        stub_stall = 1'b1;
        send_job(2, d, 7, 1'b0, ok);
        wait_rsp(ok, cyc);
        n_cmp++;
        if (!ok || cyc != TO + 2) begin
            n_bad++; $display("FAIL to_latency: got valid=%b after %0d cycles want %0d", rsp_valid, cyc, TO + 2);
        end
        n_cmp++;
        if (rsp_timeout !== 1'b1 || rsp_data !== d) begin
            n_bad++; $display("FAIL to_result: got to=%b %h want 1 %h", rsp_timeout, rsp_data, d);
        end
        accept_rsp();
        n_cmp++;
        if (rsp_timeout !== 1'b0) begin
            n_bad++; $display("FAIL to_clear: got rsp_timeout=%b want 0", rsp_timeout);
        end
        stub_stall = 1'b0;
        repeat (12) @(negedge clk);
        $display("test_timeout: latency=%0d", cyc);
    endtask

    task automatic test_reset_midsort();
        logic [VW-1:0] d;
        bit ok; int cyc;
        d = rand_vec();
        stub_stall = 1'b1;
        send_job(0, d, 8, 1'b1, ok);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (srt_data_in !== d || srt_len !== LW'(8) || srt_sort_order !== 1'b1) begin
            n_bad++; $display("FAIL wait_hold: got %h len=%0d ord=%b want %h 8 1", srt_data_in, srt_len, srt_sort_order, d);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_timeout, srt_sort_en, srt_len, srt_sort_order} !== '0
            || rsp_data !== '0 || srt_data_in !== '0) begin
            n_bad++; $display("FAIL async_reset: got vld=%b en=%b len=%0d din=%h want all 0",
                              rsp_valid, srt_sort_en, srt_len, srt_data_in);
        end
        @(negedge clk);
        rst = 1'b0;
        stub_stall = 1'b0;
        model_ptr = 0;
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL stray_done: got rsp_valid=%b want 0", rsp_valid);
        end
        d = rand_vec();
        send_job(2, d, 8, 1'b0, ok);
        wait_rsp(ok, cyc);
        n_cmp++;
        if (!ok || rsp_id !== 2'd2 || rsp_data !== ref_sort(d, 8, 1'b0)) begin
            n_bad++; $display("FAIL post_reset: got id=%0d %h want id=2 %h", rsp_id, rsp_data, ref_sort(d, 8, 1'b0));
        end
        accept_rsp();
        $display("test_reset_midsort: recovered id=%0d", rsp_id);
    endtask

    task automatic test_random();
        logic [NR-1:0] mask, exp_gnt;
        bit ok; int cyc; int exp;
        pulse_reset();
        for (int r = 0; r < 16; r++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            @(negedge clk);
            for (int k = 0; k < NR; k++)
                set_job(k, rand_vec(), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            req_valid = mask;
            exp = next_grant(mask, model_ptr);
            exp_gnt = '0;
            exp_gnt[exp] = 1'b1;
            #1;
            n_cmp++;
            if (req_ready !== exp_gnt) begin
                n_bad++; $display("FAIL rand_grant[%0d]: got %b want %b", r, req_ready, exp_gnt);
            end
            @(negedge clk);
            req_valid = '0;
            model_ptr = (exp + 1) % NR;
            wait_rsp(ok, cyc);
            n_cmp++;
            if (!ok || int'(rsp_id) != exp || rsp_timeout !== 1'b0
                || rsp_data !== ref_sort(jd[exp], jl[exp], jo[exp])) begin
                n_bad++;
                $display("FAIL rand_rsp[%0d]: got id=%0d to=%b %h want id=%0d %h", r, rsp_id, rsp_timeout,
                         rsp_data, exp, ref_sort(jd[exp], jl[exp], jo[exp]));
            end
            $display("test_random: job %0d id=%0d len=%0d ord=%0d", r, exp, jl[exp], jo[exp]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept_rsp();
        end
        n_cmp++;
        if (hold_bad !== 1'b0) begin
            n_bad++; $display("FAIL sorter_inputs_held: got changed=%b want 0", hold_bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_len = '0;
        req_order = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_desc();
        test_bypass();
        test_backpressure();
        test_timeout();
        test_reset_midsort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1);
    end

endmodule
